// File: rtl/bcd_counter_display.sv
// Modulo-N BCD up/down counter with prescaled tick, synchronous load and a multiplexed
// active-low 7-segment driver. Optional leading-zero blanking: BCD_COUNTER_LEADING_ZERO_BLANK_EN.
module bcd_counter_display #(
  parameter int DIGITS    = 2,
  parameter int MAX_VALUE = 59,
  parameter int TICK_DIV  = 100000000,
  parameter int SCAN_DIV  = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg
);
  localparam int CW = 4*DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [CW-1:0] to_bcd(int unsigned v);
    logic [CW-1:0] r;
    int unsigned   t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] inc_val, dec_val;
  logic          carry, borrow, load_ok, tick;
  logic [3:0]    digit;
  logic          blank;

  assign tick = en && (pre_q == PW'(TICK_DIV-1));

  // Ripple BCD increment/decrement: a digit changes only while carry/borrow is still pending.
  always_comb begin
    inc_val = count_q;
    dec_val = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) inc_val[4*i +: 4] = 4'd0;
        else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) dec_val[4*i +: 4] = 4'd9;
        else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // With every nibble <= 9, comparing the raw vectors orders them like the decimal values.
  always_comb begin
    load_ok = (load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++)
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
  end

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      pre_d   = '0;
      count_d = load_ok ? load_val : MAX_BCD;
    end else if (tick) begin
      pre_d = '0;
      if (up) begin
        if (count_q == MAX_BCD) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else count_d = inc_val;
      end else begin
        if (count_q == '0) begin
          count_d = MAX_BCD;
          wrap_d  = 1'b1;
        end else count_d = dec_val;
      end
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV-1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
    end
  end

`ifdef BCD_COUNTER_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++)
      if (count_q[4*i +: 4] != 4'd0) msd = IW'(i);
    blank = (idx_q > msd);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    digit = count_q[4*idx_q +: 4];
    an    = ~(DIGITS'(1) << idx_q);
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    if (blank) seg = 7'b1111111;
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench for bcd_counter_display: two instances (TICK_DIV 1 and 4) share stimulus;
// expected count/wrap go into a queue that a per-cycle monitor pops and compares.
module tb_bcd_counter_display;
  localparam int MAXV = 59;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] c1, c4;
  logic       w1, w4;
  logic [1:0] an1, an4;
  logic [6:0] seg1, seg4;

  bcd_counter_display #(.DIGITS(2), .MAX_VALUE(59), .TICK_DIV(1), .SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(c1), .wrap(w1), .an(an1), .seg(seg1));

  bcd_counter_display #(.DIGITS(2), .MAX_VALUE(59), .TICK_DIV(4), .SCAN_DIV(3)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(c4), .wrap(w4), .an(an4), .seg(seg4));

  always #5 clk = ~clk;

  typedef struct {
    int c1;
    bit w1;
    int c4;
    bit w4;
  } exp_t;

  exp_t q[$];
  int   m1 = 0, m4 = 0, pre4 = 0, cyc = 0;
  int   checks = 0, errors = 0;

  function automatic logic [7:0] bcd(int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [6:0] seg_ref(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] seg_shown(int v, int idx);
    int d;
    d = (idx == 0) ? v % 10 : v / 10;
`ifdef BCD_COUNTER_LEADING_ZERO_BLANK_EN
    if (idx == 1 && v < 10) return 7'b1111111;
`endif
    return seg_ref(d);
  endfunction

  function automatic int next_val(int v, bit dir, output bit w);
    w = 1'b0;
    if (dir) begin
      if (v == MAXV) begin
        w = 1'b1;
        return 0;
      end
      return v + 1;
    end
    if (v == 0) begin
      w = 1'b1;
      return MAXV;
    end
    return v - 1;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus and queue what both counters must show after the edge.
  task automatic drive(bit e, bit u, bit l, logic [7:0] lv);
    exp_t x;
    bit   w;
    int   hi, lo;
    @(negedge clk);
    en = e; up = u; load = l; load_val = lv;
    x.w1 = 1'b0;
    x.w4 = 1'b0;
    if (l) begin
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      m1 = (hi > 9 || lo > 9 || hi*10 + lo > MAXV) ? MAXV : hi*10 + lo;
      m4 = m1;
      pre4 = 0;
    end else if (e) begin
      m1 = next_val(m1, u, w);
      x.w1 = w;
      if (pre4 == 3) begin
        pre4 = 0;
        m4 = next_val(m4, u, w);
        x.w4 = w;
      end else pre4++;
    end
    x.c1 = m1;
    x.c4 = m4;
    q.push_back(x);
  endtask

  task automatic reset_checks(string tag);
    check({tag, "_count1"}, c1, 8'h00);
    check({tag, "_wrap1"}, w1, 1'b0);
    check({tag, "_an1"}, an1, 2'b10);
    check({tag, "_seg1"}, seg1, 7'b1000000);
    check({tag, "_count4"}, c4, 8'h00);
    check({tag, "_an4"}, an4, 2'b10);
  endtask

  always @(posedge clk) begin
    exp_t x;
    int   i1, i4;
    #1;
    if (!rst) cyc = 0;
    else begin
      cyc++;
      if (q.size() > 0) begin
        x = q.pop_front();
        i1 = cyc % 2;
        i4 = (cyc / 3) % 2;
        check("count1", c1, bcd(x.c1));
        check("wrap1", w1, x.w1);
        check("count4", c4, bcd(x.c4));
        check("wrap4", w4, x.w4);
        check("an1", an1, (i1 == 1) ? 2'b01 : 2'b10);
        check("seg1", seg1, seg_shown(x.c1, i1));
        check("an4", an4, (i4 == 1) ? 2'b01 : 2'b10);
        check("seg4", seg4, seg_shown(x.c4, i4));
      end
    end
  end

  initial begin
    logic [7:0] lv;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // asynchronous reset from a nonzero count
    drive(0, 1, 1, 8'h23);
    drive(0, 1, 0, 8'h00);
    @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    m1 = 0; m4 = 0; pre4 = 0;
    #1;
    reset_checks("rst_now");
    repeat (3) begin
      @(posedge clk);
      #2;
      reset_checks("rst_hold");
    end
    @(negedge clk);
    rst = 1'b1;

    // up: carry and terminal wrap
    drive(0, 1, 1, 8'h08);
    repeat (2) drive(1, 1, 0, 8'h00);
    drive(0, 1, 1, 8'h58);
    repeat (3) drive(1, 1, 0, 8'h00);

    // down: borrow and wrap from zero
    drive(0, 0, 1, 8'h10);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h00);
    repeat (2) drive(1, 0, 0, 8'h00);

    // loads, including out-of-range, non-BCD, and load colliding with a tick
    drive(0, 1, 1, 8'h45);
    drive(0, 1, 1, 8'h77);
    drive(0, 1, 1, 8'h3A);
    drive(1, 1, 1, 8'h21);
    drive(1, 1, 0, 8'h00);

    // prescaler with an enable gap mid-period
    drive(0, 1, 1, 8'h00);
    repeat (9) drive(1, 1, 0, 8'h00);
    repeat (2) drive(0, 1, 0, 8'h00);
    repeat (6) drive(1, 1, 0, 8'h00);

    // display scan on fixed values
    drive(0, 1, 1, 8'h37);
    repeat (6) drive(0, 1, 0, 8'h00);
    drive(0, 1, 1, 8'h05);
    repeat (6) drive(0, 1, 0, 8'h00);

    // randomized mix, biased toward legal values near the terminals
    repeat (400) begin
      if ($urandom % 3 == 0) lv = {4'($urandom % 6), 4'($urandom % 10)};
      else lv = 8'($urandom);
      drive(($urandom % 10) < 7, 1'($urandom % 2), ($urandom % 12) == 0, lv);
    end

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_counter_display.md
# bcd_counter_display

- Parametrised modulo-N BCD counter with a multiplexed 7-segment display driver.
- Counts up or down over 0..MAX_VALUE across DIGITS decimal digits at a prescaled rate, and supports synchronous load.
- Emits a one-cycle wrap pulse.
- Time-multiplexes the digits onto a shared active-low segment bus with active-low anodes.
- Sits between the board clock/reset and the on-board display.
- Replaces the fixed single-digit counter/decoder pairs used in earlier labs.

## Interface
Parameters:
- DIGITS, 2: number of BCD digits; range 1..8
- MAX_VALUE, 59: terminal count, decimal; must be < 10**DIGITS
- TICK_DIV, 100000000: enabled clk cycles per count step; ≥1 (1 = step every enabled cycle)
- SCAN_DIV, 100000: clk cycles per display digit; ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- en  in  1  count enable; low freezes prescaler and count
- up  in  1  direction: 1 = up, 0 = down
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  BCD load value, digit 0 in [3:0]
- count  out  4*DIGITS  current BCD count, digit 0 in [3:0]
- wrap  out  1  one-cycle pulse on terminal wrap
- an  out  DIGITS  digit anodes, active-low, one-hot
- seg  out  7  segments, active-low, seg[6]=g … seg[0]=a

## Operation
- Prescaler counts 0..TICK_DIV-1 while en=1 and holds while en=0. A tick is the cycle it sits at TICK_DIV-1 with en=1; the prescaler returns to 0 on that cycle.
- On a tick with up=1:
  - count==MAX_VALUE → count=0 and wrap=1.
  - Otherwise BCD increment with per-digit carry (09→10).
- On a tick with up=0:
  - count==0 → count=MAX_VALUE and wrap=1.
  - Otherwise BCD decrement with borrow (10→09).
- load=1 has priority over a tick, and acts even when en=0:
  - count ← load_val.
  - A load_val above MAX_VALUE, or one with any nibble >9, loads MAX_VALUE.
  - Prescaler clears to 0.
  - wrap stays 0.
- Direction changes take effect at the next tick.
- Scan counter is free-running and independent of en/load. It advances the digit index every SCAN_DIV cycles over 0..DIGITS-1, then wraps to 0.
- an = ~(1 << index).
- seg decodes the selected digit: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, otherwise 1111111.

## Timing
- Reset (rst=0) immediately forces: count=0, prescaler=0, scan index=0, wrap=0, an=~1, seg=1000000. These hold until the first rising edge after rst returns high.
- count and wrap are registered and update on the tick/load edge. wrap is high in exactly the cycle count first shows the wrapped value.
- an/seg are combinational from the registered scan index and count. Zero added latency: a count change shows on seg in the same cycle if that digit is selected.
- First tick after reset or load: on the TICK_DIV-th enabled cycle.
- rst asserted mid-period discards prescaler progress. No wrap pulse is generated by reset.

## Configuration
- BCD_COUNTER_LEADING_ZERO_BLANK_EN defined:
  - Any digit above the most significant nonzero digit displays 1111111 (blank).
  - Its anode is still driven.
  - Digit 0 is always displayed.
- Not defined: all digits display their value, including leading zeros.
- count output is identical in both builds.

## Test plan
All with DIGITS=2, MAX_VALUE=59, TICK_DIV=1, SCAN_DIV=1 unless stated.
- Reset: count at 0x23, drive rst=0 between edges → count=0x00, wrap=0, an=2'b10, seg=1000000 before the next edge. Values hold through 3 edges while rst=0.
- Up wrap/carry, en=1, up=1, from 0x08: sequence 0x09, 0x10. Load 0x58 → 0x59, then 0x00 with wrap=1 for exactly 1 cycle.
- Down wrap/borrow, up=0, from 0x10: sequence 0x09. From 0x00 → 0x59 with wrap=1 for 1 cycle.
- Load:
  - load_val=0x45 with en=0 → count=0x45 next edge.
  - load_val=0x77 → 0x59.
  - load_val=0x3A → 0x59.
  - load with a tick in the same cycle → loaded value, no increment.
- Prescaler, TICK_DIV=4: count steps every 4th enabled cycle. Deasserting en for 2 cycles mid-period delays the step by exactly 2 cycles.
- Scan/blanking:
  - count=0x37: an alternates 10/01, with seg 1111000/0110000.
  - count=0x05 with BCD_COUNTER_LEADING_ZERO_BLANK_EN: digit 1 shows 1111111.
  - count=0x05 without the macro: digit 1 shows 1000000.
